// File: rtl/apb_initiator_if.sv
// apb_initiator_if: command port and APB bus bundle; master is the initiator side, slave is the requester/peripheral side
interface apb_initiator_if #(
    parameter int APB_ADDR_WIDTH = 12
);
    logic                      req_i;
    logic                      we_i;
    logic [APB_ADDR_WIDTH-1:0] addr_i;
    logic [31:0]               wdata_i;
    logic                      gnt_o;
    logic                      rvalid_o;
    logic [31:0]               rdata_o;
    logic                      err_o;
    logic [APB_ADDR_WIDTH-1:0] PADDR;
    logic [31:0]               PWDATA;
    logic                      PWRITE;
    logic                      PSEL;
    logic                      PENABLE;
    logic [31:0]               PRDATA;
    logic                      PREADY;
    logic                      PSLVERR;

    modport master (
        input  req_i, we_i, addr_i, wdata_i, PRDATA, PREADY, PSLVERR,
        output gnt_o, rvalid_o, rdata_o, err_o, PADDR, PWDATA, PWRITE, PSEL, PENABLE
    );

    modport slave (
        output req_i, we_i, addr_i, wdata_i, PRDATA, PREADY, PSLVERR,
        input  gnt_o, rvalid_o, rdata_o, err_o, PADDR, PWDATA, PWRITE, PSEL, PENABLE
    );
endinterface

// File: rtl/apb_initiator.sv
// apb_initiator: single-outstanding request/grant to APB bridge; define APB_INITIATOR_TIMEOUT_EN to abort stalled ACCESS phases
module apb_initiator #(
    parameter int APB_ADDR_WIDTH = 12,
    parameter int TIMEOUT_CYCLES = 256
) (
    input logic              HCLK,
    input logic              HRESETn,
    apb_initiator_if.master  bus
);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_e;

    state_e                    state_q, state_d;
    logic [APB_ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic [31:0]               pwdata_q, pwdata_d;
    logic                      pwrite_q, pwrite_d;
    logic                      rvalid_q, rvalid_d;
    logic [31:0]               rdata_q, rdata_d;
    logic                      err_q, err_d;
    logic                      timeout;

`ifdef APB_INITIATOR_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign timeout = cnt_q == CNT_W'(TIMEOUT_CYCLES);

    // stall counter: cleared while in SETUP so it starts at zero on ACCESS entry
    always_comb begin
        cnt_d = state_q == SETUP ? '0 : (state_q == ACCESS && !bus.PREADY) ? cnt_q + CNT_W'(1) : cnt_q;
    end

    // stall counter register
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end
`else
    assign timeout = 1'b0;
`endif

    assign bus.gnt_o    = state_q == IDLE && bus.req_i;
    assign bus.PSEL     = state_q != IDLE;
    assign bus.PENABLE  = state_q == ACCESS;
    assign bus.PADDR    = paddr_q;
    assign bus.PWDATA   = pwdata_q;
    assign bus.PWRITE   = pwrite_q;
    assign bus.rvalid_o = rvalid_q;
    assign bus.rdata_o  = rdata_q;
    assign bus.err_o    = err_q;

    // next state, command capture at grant, and response on PREADY (or timeout, where PREADY wins)
    always_comb begin
        state_d  = state_q;
        paddr_d  = paddr_q;
        pwdata_d = pwdata_q;
        pwrite_d = pwrite_q;
        rvalid_d = 1'b0;
        rdata_d  = rdata_q;
        err_d    = err_q;
        case (state_q)
            IDLE: if (bus.req_i) begin
                state_d  = SETUP;
                paddr_d  = bus.addr_i & ~APB_ADDR_WIDTH'(3);
                pwdata_d = bus.wdata_i;
                pwrite_d = bus.we_i;
            end
            SETUP: state_d = ACCESS;
            ACCESS: if (bus.PREADY || timeout) begin
                state_d  = IDLE;
                rvalid_d = 1'b1;
                err_d    = bus.PREADY ? bus.PSLVERR : 1'b1;
                rdata_d  = bus.PREADY && !pwrite_q ? bus.PRDATA : 32'h0;
            end
            default: state_d = IDLE;
        endcase
    end

    // state and output registers; async reset drops PSEL/PENABLE and discards any pending response
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q  <= IDLE;
            paddr_q  <= '0;
            pwdata_q <= '0;
            pwrite_q <= 1'b0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            paddr_q  <= paddr_d;
            pwdata_q <= pwdata_d;
            pwrite_q <= pwrite_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end
endmodule

// File: tb/tb_apb_initiator.sv
// tb_apb_initiator: directed cycle-accurate checks of the APB initiator command/response and bus timing
module tb_apb_initiator;
    logic HCLK = 1'b0;
    logic HRESETn = 1'b0;
    int   tests = 0;
    int   fails = 0;

    apb_initiator_if #(.APB_ADDR_WIDTH(12)) bus ();

    apb_initiator #(.APB_ADDR_WIDTH(12), .TIMEOUT_CYCLES(4)) dut (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .bus     (bus)
    );

    always #5 HCLK = ~HCLK;

    task automatic tick;
        @(posedge HCLK);
        #1;
    endtask

    task automatic test_reset;
        tick;
        tick;
        #2;
        tests++;
        if ({bus.PSEL, bus.PENABLE, bus.PWRITE, bus.rvalid_o, bus.err_o, bus.gnt_o} !== 6'b0) begin
            fails++;
            $display("FAIL reset_ctrl: got %b exp 000000", {bus.PSEL, bus.PENABLE, bus.PWRITE, bus.rvalid_o, bus.err_o, bus.gnt_o});
        end
        tests++;
        if ({bus.PADDR, bus.PWDATA, bus.rdata_o} !== 76'h0) begin
            fails++;
            $display("FAIL reset_data: got %h exp 0", {bus.PADDR, bus.PWDATA, bus.rdata_o});
        end
        tick;
        HRESETn = 1'b1;
    endtask

    task automatic test_write;
        tick;
        bus.req_i = 1'b1; bus.we_i = 1'b1; bus.addr_i = 12'h000; bus.wdata_i = 32'h1; bus.PREADY = 1'b1;
        #2;
        tests++;
        if ({bus.gnt_o, bus.PSEL} !== 2'b10) begin
            fails++;
            $display("FAIL wr_grant: got gnt/psel %b exp 10", {bus.gnt_o, bus.PSEL});
        end
        tick;
        bus.req_i = 1'b0;
        #2;
        tests++;
        if ({bus.PSEL, bus.PENABLE, bus.PWRITE, bus.PADDR, bus.PWDATA, bus.gnt_o} !== {3'b101, 12'h000, 32'h1, 1'b0}) begin
            fails++;
            $display("FAIL wr_setup: got sel/en/wr %b addr %h wdata %h gnt %b", {bus.PSEL, bus.PENABLE, bus.PWRITE}, bus.PADDR, bus.PWDATA, bus.gnt_o);
        end
        tick;
        #2;
        tests++;
        if ({bus.PSEL, bus.PENABLE, bus.rvalid_o} !== 3'b110) begin
            fails++;
            $display("FAIL wr_access: got sel/en/rvalid %b exp 110", {bus.PSEL, bus.PENABLE, bus.rvalid_o});
        end
        tick;
        #2;
        tests++;
        if ({bus.rvalid_o, bus.err_o, bus.rdata_o, bus.PSEL} !== {2'b10, 32'h0, 1'b0}) begin
            fails++;
            $display("FAIL wr_resp: got rvalid/err %b rdata %h psel %b exp 10 0 0", {bus.rvalid_o, bus.err_o}, bus.rdata_o, bus.PSEL);
        end
        tick;
        #2;
        tests++;
        if (bus.rvalid_o !== 1'b0) begin
            fails++;
            $display("FAIL wr_strobe_one_cycle: got rvalid %b exp 0", bus.rvalid_o);
        end
    endtask

    task automatic test_read_wait;
        tick;
        bus.req_i = 1'b1; bus.we_i = 1'b0; bus.addr_i = 12'h007; bus.PRDATA = 32'hA5A5_0001; bus.PREADY = 1'b0;
        #2;
        tests++;
        if (bus.gnt_o !== 1'b1) begin
            fails++;
            $display("FAIL rd_grant: got %b exp 1", bus.gnt_o);
        end
        for (int c = 1; c <= 6; c++) begin
            tick;
            bus.req_i = 1'b0;
            bus.PREADY = (c == 5);
            #2;
            tests++;
            if ({bus.PSEL, bus.PENABLE, bus.rvalid_o} !== {c <= 5, c >= 2 && c <= 5, c == 6}) begin
                fails++;
                $display("FAIL rd_wait_c%0d: got sel/en/rvalid %b", c, {bus.PSEL, bus.PENABLE, bus.rvalid_o});
            end
            if (c <= 5) begin
                tests++;
                if ({bus.PADDR, bus.PWRITE} !== {12'h004, 1'b0}) begin
                    fails++;
                    $display("FAIL rd_addr_c%0d: got addr %h wr %b exp 004 0", c, bus.PADDR, bus.PWRITE);
                end
            end
        end
        tests++;
        if ({bus.rdata_o, bus.err_o} !== {32'hA5A5_0001, 1'b0}) begin
            fails++;
            $display("FAIL rd_data: got rdata %h err %b exp a5a50001 0", bus.rdata_o, bus.err_o);
        end
    endtask

    task automatic test_slverr;
        tick;
        bus.req_i = 1'b1; bus.we_i = 1'b0; bus.addr_i = 12'h010; bus.PRDATA = 32'h1234_5678; bus.PREADY = 1'b1; bus.PSLVERR = 1'b1;
        tick;
        bus.req_i = 1'b0;
        tick;
        tick;
        bus.PSLVERR = 1'b0;
        #2;
        tests++;
        if ({bus.rvalid_o, bus.err_o, bus.rdata_o} !== {2'b11, 32'h1234_5678}) begin
            fails++;
            $display("FAIL slverr_resp: got rvalid/err %b rdata %h exp 11 12345678", {bus.rvalid_o, bus.err_o}, bus.rdata_o);
        end
        tick;
        #2;
        tests++;
        if ({bus.rvalid_o, bus.err_o, bus.rdata_o} !== {2'b01, 32'h1234_5678}) begin
            fails++;
            $display("FAIL slverr_hold: got rvalid/err %b rdata %h exp 01 12345678", {bus.rvalid_o, bus.err_o}, bus.rdata_o);
        end
    endtask

    task automatic test_back_to_back;
        for (int c = 0; c <= 6; c++) begin
            tick;
            if (c == 0) begin
                bus.req_i = 1'b1; bus.we_i = 1'b1; bus.addr_i = 12'h100; bus.wdata_i = 32'hAA; bus.PREADY = 1'b1; bus.PRDATA = 32'h0BAD_F00D;
            end
            if (c == 1) begin
                bus.we_i = 1'b0; bus.addr_i = 12'h204;
            end
            if (c == 4) bus.req_i = 1'b0;
            #2;
            tests++;
            if ({bus.gnt_o, bus.PSEL, bus.PENABLE, bus.rvalid_o} !== {c == 0 || c == 3, c == 1 || c == 2 || c == 4 || c == 5, c == 2 || c == 5, c == 3 || c == 6}) begin
                fails++;
                $display("FAIL b2b_c%0d: got gnt/sel/en/rvalid %b", c, {bus.gnt_o, bus.PSEL, bus.PENABLE, bus.rvalid_o});
            end
        end
        tests++;
        if ({bus.rdata_o, bus.PADDR, bus.PWRITE} !== {32'h0BAD_F00D, 12'h204, 1'b0}) begin
            fails++;
            $display("FAIL b2b_second: got rdata %h addr %h wr %b exp 0badf00d 204 0", bus.rdata_o, bus.PADDR, bus.PWRITE);
        end
    endtask

`ifdef APB_INITIATOR_TIMEOUT_EN
    task automatic test_timeout;
        for (int w = 0; w < 2; w++) begin
            tick;
            bus.req_i = 1'b1; bus.we_i = 1'b0; bus.addr_i = 12'h020; bus.PRDATA = 32'hDEAD_BEEF; bus.PREADY = 1'b0;
            for (int c = 1; c <= 7; c++) begin
                tick;
                bus.req_i = 1'b0;
                bus.PREADY = (w == 1 && c == 6);
                #2;
                tests++;
                if ({bus.PSEL, bus.PENABLE, bus.rvalid_o} !== {c <= 6, c >= 2 && c <= 6, c == 7}) begin
                    fails++;
                    $display("FAIL timeout_w%0d_c%0d: got sel/en/rvalid %b", w, c, {bus.PSEL, bus.PENABLE, bus.rvalid_o});
                end
            end
            tests++;
            if ({bus.err_o, bus.rdata_o} !== (w == 0 ? {1'b1, 32'h0} : {1'b0, 32'hDEAD_BEEF})) begin
                fails++;
                $display("FAIL timeout_resp_w%0d: got err %b rdata %h", w, bus.err_o, bus.rdata_o);
            end
            bus.PREADY = 1'b0;
        end
    endtask
`else
    task automatic test_timeout;
        int pulses;
        pulses = 0;
        tick;
        bus.req_i = 1'b1; bus.we_i = 1'b0; bus.addr_i = 12'h020; bus.PREADY = 1'b0;
        for (int c = 1; c <= 1000; c++) begin
            tick;
            bus.req_i = 1'b0;
            #2;
            if (bus.rvalid_o) pulses++;
        end
        tests++;
        if ({pulses, bus.PSEL, bus.PENABLE} !== {32'd0, 2'b11}) begin
            fails++;
            $display("FAIL no_timeout: got rvalid pulses %0d sel/en %b exp 0 11", pulses, {bus.PSEL, bus.PENABLE});
        end
        HRESETn = 1'b0;
        tick;
        HRESETn = 1'b1;
    endtask
`endif

    task automatic test_reset_mid;
        tick;
        bus.req_i = 1'b1; bus.we_i = 1'b0; bus.addr_i = 12'h030; bus.PREADY = 1'b0; bus.PRDATA = 32'h5555_AAAA;
        tick;
        bus.req_i = 1'b0;
        tick;
        #2;
        tests++;
        if ({bus.PSEL, bus.PENABLE} !== 2'b11) begin
            fails++;
            $display("FAIL rstmid_access: got sel/en %b exp 11", {bus.PSEL, bus.PENABLE});
        end
        bus.PREADY = 1'b1;
        HRESETn = 1'b0;
        #1;
        tests++;
        if ({bus.PSEL, bus.PENABLE} !== 2'b00) begin
            fails++;
            $display("FAIL rstmid_async: got sel/en %b exp 00", {bus.PSEL, bus.PENABLE});
        end
        tick;
        tick;
        HRESETn = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick;
            #2;
            tests++;
            if ({bus.rvalid_o, bus.PSEL} !== 2'b00) begin
                fails++;
                $display("FAIL rstmid_idle_c%0d: got rvalid/psel %b exp 00", c, {bus.rvalid_o, bus.PSEL});
            end
        end
        tick;
        bus.req_i = 1'b1; bus.we_i = 1'b1; bus.addr_i = 12'h044; bus.wdata_i = 32'h77;
        #2;
        tests++;
        if (bus.gnt_o !== 1'b1) begin
            fails++;
            $display("FAIL rstmid_regrant: got gnt %b exp 1", bus.gnt_o);
        end
        tick;
        bus.req_i = 1'b0;
        #2;
        tests++;
        if ({bus.PSEL, bus.PENABLE, bus.PWRITE, bus.PADDR} !== {3'b101, 12'h044}) begin
            fails++;
            $display("FAIL rstmid_setup: got sel/en/wr %b addr %h exp 101 044", {bus.PSEL, bus.PENABLE, bus.PWRITE}, bus.PADDR);
        end
        tick;
        tick;
        #2;
        tests++;
        if ({bus.rvalid_o, bus.err_o} !== 2'b10) begin
            fails++;
            $display("FAIL rstmid_resp: got rvalid/err %b exp 10", {bus.rvalid_o, bus.err_o});
        end
    endtask

    initial begin
        bus.req_i = 1'b0; bus.we_i = 1'b0; bus.addr_i = '0; bus.wdata_i = '0;
        bus.PRDATA = '0; bus.PREADY = 1'b0; bus.PSLVERR = 1'b0;
        test_reset;
        test_write;
        test_read_wait;
        test_slverr;
        test_back_to_back;
        test_timeout;
        test_reset_mid;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
